// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 codes, FSM state type,
// and the helpers that derive byte enables and the effective lane offset.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } lsu_state_t;

  // size is funct3[1:0]: 00 byte, 01 half, 10 word; loads always read the full word
  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off,
                                         input logic write);
    if (!write) return 4'b1111;
    case (size)
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  // Misaligned offset bits are dropped so a misaligned access lands aligned-down
  function automatic logic [1:0] eff_off(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      2'b00:   return addr_lo;
      2'b01:   return {addr_lo[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store byte enables / lane replication and
// load lane extraction with sign or zero extension.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int DWIDTH = 32
) (
  input  logic [2:0]        funct3,
  input  logic [1:0]        off,
  input  logic              write,
  input  logic [DWIDTH-1:0] store_data,
  input  logic [DWIDTH-1:0] rdata,
  output logic [3:0]        be,
  output logic [DWIDTH-1:0] wdata,
  output logic [DWIDTH-1:0] load_data
);

  logic [DWIDTH-1:0] lane;

  always_comb begin
    be   = byte_en(funct3[1:0], off, write);
    lane = rdata >> {off, 3'b000};

    case (funct3[1:0])
      2'b00:   wdata = {4{store_data[7:0]}};
      2'b01:   wdata = {2{store_data[15:0]}};
      default: wdata = store_data;
    endcase

    case (funct3)
      F3_B:    load_data = {{24{lane[7]}}, lane[7:0]};
      F3_H:    load_data = {{16{lane[15]}}, lane[15:0]};
      F3_BU:   load_data = {24'd0, lane[7:0]};
      F3_HU:   load_data = {16'd0, lane[15:0]};
      default: load_data = lane;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I data-memory access stage with valid/ready bus, stall, and fault reporting.
// Build option: define LSU_MISALIGN_TRAP_EN to fault misaligned halfword/word accesses.
//
// state | meaning
// IDLE  | waiting for LSU_Req; captures request and checks legality
// REQ   | Mem_Req asserted, waiting for Mem_Ready or timeout
// DONE  | one-cycle retire pulse, results valid
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DWIDTH         = 32,
  parameter int AWIDTH         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              Clk,
  input  logic              Rst_N,
  input  logic              LSU_Req,
  input  logic              LSU_Write,
  input  logic [2:0]        LSU_Funct3,
  input  logic [AWIDTH-1:0] LSU_Addr,
  input  logic [DWIDTH-1:0] LSU_Store_Data,
  output logic              LSU_Stall,
  output logic              LSU_Done,
  output logic [DWIDTH-1:0] LSU_Load_Data,
  output logic              LSU_Fault,
  output logic [AWIDTH-1:0] LSU_Fault_Addr,
  output logic              Mem_Req,
  output logic              Mem_We,
  output logic [AWIDTH-1:0] Mem_Addr,
  output logic [3:0]        Mem_Be,
  output logic [DWIDTH-1:0] Mem_Wdata,
  input  logic              Mem_Ready,
  input  logic [DWIDTH-1:0] Mem_Rdata,
  input  logic              Mem_Err
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LOAD = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

  lsu_state_t        state;
  logic [AWIDTH-1:0] addr_q;
  logic [2:0]        funct3_q;
  logic              write_q;
  logic [DWIDTH-1:0] data_q;
  logic [1:0]        off_q;
  logic [TW-1:0]     cnt_q;
  logic [DWIDTH-1:0] load_data_q;
  logic              fault_q;
  logic [AWIDTH-1:0] fault_addr_q;

  logic              funct3_ok;
  logic              misalign;
  logic              in_req;
  logic [3:0]        be;
  logic [DWIDTH-1:0] wdata;
  logic [DWIDTH-1:0] ld_ext;

  assign funct3_ok = LSU_Write ? (LSU_Funct3 inside {F3_B, F3_H, F3_W})
                               : (LSU_Funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = ((LSU_Funct3[1:0] == 2'b01) && LSU_Addr[0]) ||
                    ((LSU_Funct3[1:0] == 2'b10) && (LSU_Addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  lsu_align #(.DWIDTH(DWIDTH)) u_align (
    .funct3     (funct3_q),
    .off        (off_q),
    .write      (write_q),
    .store_data (data_q),
    .rdata      (Mem_Rdata),
    .be         (be),
    .wdata      (wdata),
    .load_data  (ld_ext)
  );

  always_ff @(posedge Clk or negedge Rst_N) begin
    if (!Rst_N) begin
      state        <= IDLE;
      addr_q       <= '0;
      funct3_q     <= '0;
      write_q      <= 1'b0;
      data_q       <= '0;
      off_q        <= '0;
      cnt_q        <= '0;
      load_data_q  <= '0;
      fault_q      <= 1'b0;
      fault_addr_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (LSU_Req) begin
            addr_q   <= LSU_Addr;
            funct3_q <= LSU_Funct3;
            write_q  <= LSU_Write;
            data_q   <= LSU_Store_Data;
            off_q    <= eff_off(LSU_Funct3[1:0], LSU_Addr[1:0]);
            cnt_q    <= TO_LOAD;
            if (funct3_ok && !misalign) begin
              state <= REQ;
            end else begin
              state        <= DONE;
              fault_q      <= 1'b1;
              fault_addr_q <= LSU_Addr;
              load_data_q  <= '0;
            end
          end
        end
        REQ: begin
          if (Mem_Ready) begin
            state        <= DONE;
            fault_q      <= Mem_Err;
            fault_addr_q <= Mem_Err ? addr_q : '0;
            load_data_q  <= (Mem_Err || write_q) ? '0 : ld_ext;
          end else if (TO_EN && (cnt_q == '0)) begin
            state        <= DONE;
            fault_q      <= 1'b1;
            fault_addr_q <= addr_q;
            load_data_q  <= '0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Bus outputs are qualified by REQ so nothing leaks onto the bus outside an access
  assign in_req         = (state == REQ);
  assign Mem_Req        = in_req;
  assign Mem_We         = in_req && write_q;
  assign Mem_Addr       = in_req ? {addr_q[AWIDTH-1:2], 2'b00} : '0;
  assign Mem_Be         = in_req ? be : 4'b0000;
  assign Mem_Wdata      = (in_req && write_q) ? wdata : '0;

  assign LSU_Stall      = ((state == IDLE) && LSU_Req) || in_req;
  assign LSU_Done       = (state == DONE);
  assign LSU_Load_Data  = load_data_q;
  assign LSU_Fault      = fault_q;
  assign LSU_Fault_Addr = fault_addr_q;

endmodule
